cam_udp_packer: RTL
===================

CAM_UDP_PACKER -- requirements
Module: cam_udp_packer

Interface
REQ-001 SHALL have parameter PAY_LEN, default 1024, payload bytes per UDP packet (range 16..1400).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2048, byte buffer depth (power of two, at least 2*PAY_LEN).
REQ-003 SHALL have port I_clk50m, input, 1: RMII 50 MHz clock, the only clock.
REQ-004 SHALL have port I_rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port I_pix_data, input, 8: camera byte.
REQ-006 SHALL have port I_pix_valid, input, 1: I_pix_data is valid this cycle.
REQ-007 SHALL have port I_frame_start, input, 1: one-cycle pulse marking the first byte of a new frame.
REQ-008 SHALL have port I_mac_busy, input, 1: MAC transmitting (mac O_busy).
REQ-009 SHALL have port I_data_req, input, 1: one-cycle pulse; MAC consumed the current O_data byte.
REQ-010 SHALL have port O_en, output, 1: packet-start request to MAC (mac I_en).
REQ-011 SHALL have port O_data, output, 8: current byte to MAC (mac I_data).
REQ-012 SHALL have port O_dataLen, output, 16: constant PAY_LEN+4 (mac I_dataLen).
REQ-013 SHALL have port O_ipv4sign, output, 16: IPv4 identification for the current packet.
REQ-014 SHALL have port O_overflow, output, 1: sticky flag, camera byte dropped.

Function
- REQ-015 Each camera byte with I_pix_valid=1 SHALL be written to the FIFO the same cycle; when FIFO is full, the byte SHALL be dropped and O_overflow set.
- REQ-016 FSM states SHALL be IDLE, REQ, HDR, PAY, DONE.
- REQ-017 IDLE->REQ when FIFO level >= PAY_LEN and I_mac_busy=0; O_data preloaded with header byte 0 on that edge.
- REQ-018 REQ: O_en=1; ->HDR on first cycle I_mac_busy=1; O_en=0 in every other state.
- REQ-019 Packet bytes SHALL be: frame_id[15:8], frame_id[7:0], pkt_seq[15:8], pkt_seq[7:0], then PAY_LEN FIFO bytes, big-endian.
- REQ-020 Each I_data_req SHALL advance O_data to the next byte on the following clock edge; O_data is held stable between requests.
- REQ-021 HDR->PAY after the 4th request; first FIFO byte presented on that edge (show-ahead read, zero added latency).
- REQ-022 PAY->DONE after the PAY_LEN-th request; further requests in DONE are ignored and O_data holds 8'h00.
- REQ-023 DONE->IDLE on the cycle I_mac_busy=0; pkt_seq and O_ipv4sign SHALL increment by 1 on that transition, each wrapping at 16'hFFFF->0.
- REQ-024 I_frame_start SHALL latch a pending flag; the flag is applied at the next IDLE->REQ: frame_id+1 (wraps), pkt_seq=0, flag cleared; never changes the header of a packet in flight.
- REQ-025 Simultaneous FIFO write and read SHALL keep the level unchanged; level width is clog2(FIFO_DEPTH)+1.
- REQ-026 I_data_req arriving in IDLE or REQ SHALL be ignored.
- REQ-027 If I_mac_busy falls in HDR or PAY (aborted frame): ->IDLE; the unread payload remainder SHALL be discarded from the FIFO; pkt_seq still increments.

Reset
- REQ-028 I_rst_n=0 asynchronously: state=IDLE, FIFO empty, O_en=0, O_data=0, O_overflow=0, frame_id=0, pkt_seq=0, O_ipv4sign=16'h0000, pending flag=0.
- REQ-029 Reset mid-packet SHALL abandon the packet with no further O_en until the FIFO refills to PAY_LEN.

Structure
- REQ-030 The FSM state enum and the header length constant (4) SHALL live in the shared package cam_udp_pkg.
- REQ-031 The FIFO SHALL be a separate sub-module, sync_fifo_byte (show-ahead, full/empty/level outputs, same clock and reset).

Verification
- REQ-032 Feed 1024 bytes 0x00..0xFF repeating, MAC model requests every 4 cycles -> one O_en, byte stream 00 00 00 00 00 01 ... FF, O_ipv4sign 0->1.
- REQ-033 Feed 3072 bytes continuously -> three packets, pkt_seq 0,1,2, payloads contiguous, O_overflow=0.
- REQ-034 Pulse I_frame_start during packet 1 payload -> packet 1 header unchanged; packet 2 header 00 01 00 00.
- REQ-035 Feed 2049 bytes with MAC held busy -> O_overflow=1, byte 2049 absent from the stream.
- REQ-036 Drop I_mac_busy after 100 payload bytes -> FSM returns to IDLE, FIFO level drops by 1024 total, next packet seq=1.
- REQ-037 Assert I_rst_n=0 in PAY -> all outputs at reset values in the same cycle; no O_en until 1024 new bytes arrive.

Source files
------------

// File: rtl/cam_udp_pkg.sv
// rtl/cam_udp_pkg.sv - shared FSM states, header length and header byte helper
package cam_udp_pkg;

  localparam int HDR_LEN = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HDR,
    ST_PAY,
    ST_DONE
  } state_e;

  // Header is frame_id then pkt_seq, both big-endian.
  function automatic logic [7:0] hdr_byte(input logic [15:0] frame_id,
                                          input logic [15:0] pkt_seq,
                                          input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = frame_id[15:8];
      2'd1:    b = frame_id[7:0];
      2'd2:    b = pkt_seq[15:8];
      default: b = pkt_seq[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sync_fifo_byte.sv
// rtl/sync_fifo_byte.sv - show-ahead byte FIFO with bulk skip for discarding data
module sync_fifo_byte #(
  parameter int DEPTH = 2048,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  input  logic          rd_en_i,
  input  logic          skip_en_i,
  input  logic [AW:0]   skip_cnt_i,
  output logic [7:0]    rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic          wr_ok;
  logic [AW:0]   rd_amt;

  assign full_o    = (level_q == (AW+1)'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign wr_ok     = wr_en_i && !full_o;

  // A single pop wins over a skip; the caller never asks for both at once.
  always_comb begin
    rd_amt = '0;
    if (rd_en_i && !empty_o) begin
      rd_amt = (AW+1)'(1);
    end else if (skip_en_i) begin
      rd_amt = skip_cnt_i;
    end
  end

  // Pointer and level bookkeeping; concurrent write and read cancel in the level.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      rd_ptr_q <= rd_ptr_q + rd_amt[AW-1:0];
      level_q  <= level_q + {{AW{1'b0}}, wr_ok} - rd_amt;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/cam_udp_packer.sv
// rtl/cam_udp_packer.sv - packs camera bytes into fixed-size UDP payloads for the MAC
module cam_udp_packer
  import cam_udp_pkg::*;
#(
  parameter int PAY_LEN    = 1024,
  parameter int FIFO_DEPTH = 2048
) (
  input  logic        I_clk50m,
  input  logic        I_rst_n,
  input  logic [7:0]  I_pix_data,
  input  logic        I_pix_valid,
  input  logic        I_frame_start,
  input  logic        I_mac_busy,
  input  logic        I_data_req,
  output logic        O_en,
  output logic [7:0]  O_data,
  output logic [15:0] O_dataLen,
  output logic [15:0] O_ipv4sign,
  output logic        O_overflow
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PAY_LVL = (AW+1)'(PAY_LEN);

  state_e      state_q, state_d;
  logic [15:0] frame_id_q, frame_id_d;
  logic [15:0] pkt_seq_q, pkt_seq_d;
  logic [15:0] ipv4_q, ipv4_d;
  logic        pend_q, pend_d;
  logic [7:0]  odata_q, odata_d;
  logic [1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [AW:0] pay_cnt_q, pay_cnt_d;
  logic        ovf_q, ovf_d;

  logic        fifo_rd, fifo_skip, fifo_full, fifo_empty;
  logic [AW:0] skip_cnt, fifo_level;
  logic [7:0]  fifo_rdata;

  sync_fifo_byte #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i      (I_clk50m),
    .rst_n_i    (I_rst_n),
    .wr_en_i    (I_pix_valid),
    .wr_data_i  (I_pix_data),
    .rd_en_i    (fifo_rd),
    .skip_en_i  (fifo_skip),
    .skip_cnt_i (skip_cnt),
    .rd_data_o  (fifo_rdata),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level)
  );

  assign O_en       = (state_q == ST_REQ);
  assign O_data     = odata_q;
  assign O_dataLen  = 16'(PAY_LEN + HDR_LEN);
  assign O_ipv4sign = ipv4_q;
  assign O_overflow = ovf_q;

  // Packet sequencing: launch, header, payload, wait for MAC to finish or abort.
  always_comb begin
    state_d    = state_q;
    frame_id_d = frame_id_q;
    pkt_seq_d  = pkt_seq_q;
    ipv4_d     = ipv4_q;
    pend_d     = pend_q | I_frame_start;
    odata_d    = odata_q;
    hdr_cnt_d  = hdr_cnt_q;
    pay_cnt_d  = pay_cnt_q;
    ovf_d      = ovf_q | (I_pix_valid & fifo_full);
    fifo_rd    = 1'b0;
    fifo_skip  = 1'b0;
    skip_cnt   = '0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_level >= PAY_LVL && !I_mac_busy) begin
          state_d   = ST_REQ;
          hdr_cnt_d = 2'd0;
          // A frame start seen since the last launch takes effect here only.
          if (pend_q) begin
            frame_id_d = frame_id_q + 16'd1;
            pkt_seq_d  = 16'd0;
            pend_d     = I_frame_start;
          end
          odata_d = hdr_byte(frame_id_d, pkt_seq_d, 2'd0);
        end
      end
      ST_REQ: begin
        if (I_mac_busy) begin
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (!I_mac_busy) begin
          state_d   = ST_IDLE;
          fifo_skip = 1'b1;
          skip_cnt  = PAY_LVL;
          pkt_seq_d = pkt_seq_q + 16'd1;
          odata_d   = 8'h00;
        end else if (I_data_req) begin
          if (hdr_cnt_q == 2'(HDR_LEN - 1)) begin
            state_d   = ST_PAY;
            fifo_rd   = 1'b1;
            odata_d   = fifo_rdata;
            pay_cnt_d = (AW+1)'(1);
          end else begin
            hdr_cnt_d = hdr_cnt_q + 2'd1;
            odata_d   = hdr_byte(frame_id_q, pkt_seq_q, hdr_cnt_q + 2'd1);
          end
        end
      end
      ST_PAY: begin
        // pay_cnt_q counts bytes already popped, including the one on O_data.
        if (!I_mac_busy) begin
          state_d   = ST_IDLE;
          fifo_skip = 1'b1;
          skip_cnt  = PAY_LVL - pay_cnt_q;
          pkt_seq_d = pkt_seq_q + 16'd1;
          odata_d   = 8'h00;
        end else if (I_data_req) begin
          if (pay_cnt_q == PAY_LVL) begin
            state_d = ST_DONE;
            odata_d = 8'h00;
          end else begin
            fifo_rd   = !fifo_empty;
            odata_d   = fifo_rdata;
            pay_cnt_d = pay_cnt_q + (AW+1)'(1);
          end
        end
      end
      ST_DONE: begin
        if (!I_mac_busy) begin
          state_d   = ST_IDLE;
          pkt_seq_d = pkt_seq_q + 16'd1;
          ipv4_d    = ipv4_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge I_clk50m or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q    <= ST_IDLE;
      frame_id_q <= 16'd0;
      pkt_seq_q  <= 16'd0;
      ipv4_q     <= 16'd0;
      pend_q     <= 1'b0;
      odata_q    <= 8'h00;
      hdr_cnt_q  <= 2'd0;
      pay_cnt_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_id_q <= frame_id_d;
      pkt_seq_q  <= pkt_seq_d;
      ipv4_q     <= ipv4_d;
      pend_q     <= pend_d;
      odata_q    <= odata_d;
      hdr_cnt_q  <= hdr_cnt_d;
      pay_cnt_q  <= pay_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule
